wb_mem_seg_mc: RTL

- Parametrised successor to the MEM/WB write-back data segment register.
- Drives a variable-latency data memory through a req/ack handshake instead of a fixed 1-cycle cache.
- Performs byte-lane alignment for stores and sign/zero extension for loads.
- Registers ALU/CSR write-back values and raises a memory stall to the hazard unit while a request is outstanding.

---
 rtl/wb_pkg.sv | 69 ++++++
 rtl/wb_load_extend.sv | 56 +++++
 rtl/wb_mem_seg_mc.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and helpers for the write-back memory segment:
//                load_type encoding, FSM state type, access-size and
//                natural-alignment helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Load kind encoding carried on load_type.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        LB   = 3'd1,
        LH   = 3'd2,
        LW   = 3'd3,
        LBU  = 3'd4,
        LHU  = 3'd5,
        LWU  = 3'd6,
        LD   = 3'd7
    } load_type_e;

    // Segment FSM state.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } wb_state_e;

    // Access size in bytes implied by a load kind. NONE moves no data.
    function automatic logic [3:0] load_size_bytes(input logic [2:0] lt);
        logic [3:0] n;
        n = 4'd0;
        case (load_type_e'(lt))
            LB, LBU:  n = 4'd1;
            LH, LHU:  n = 4'd2;
            LW, LWU:  n = 4'd4;
            LD:       n = 4'd8;
            default:  n = 4'd0;
        endcase
        return n;
    endfunction

    // Number of set bits in a byte mask (store size in bytes).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // True when an access of nbytes at byte offset off is naturally aligned.
    // Zero-size accesses are trivially aligned; non power-of-two sizes never are.
    function automatic logic is_aligned(input logic [2:0] off, input logic [3:0] nbytes);
        logic ok;
        ok = 1'b0;
        case (nbytes)
            4'd0, 4'd1: ok = 1'b1;
            4'd2:       ok = (off[0] == 1'b0);
            4'd4:       ok = (off[1:0] == 2'b00);
            4'd8:       ok = (off == 3'b000);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : wb_load_extend
//  Description : Combinational load-data lane selection and sign/zero
//                extension of a raw memory word.
//  Ports       : rdata_i     - raw read word (XLEN)
//                offset_i    - byte offset of the access within the word
//                load_type_i - load kind (wb_pkg encoding)
//                ext_o       - selected and extended load value (XLEN)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_load_extend
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  rdata_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [2:0]       load_type_i,
    output logic [XLEN-1:0]  ext_o
);

    logic [XLEN-1:0] w_byte_sh;
    logic [XLEN-1:0] w_half_sh;
    logic [XLEN-1:0] w_word_sh;

    // Bring the addressed lane down to bit 0; halfword lanes ignore offset[0].
    assign w_byte_sh = rdata_i >> {offset_i, 3'b000};
    assign w_half_sh = rdata_i >> {offset_i[OFF_W-1:1], 4'b0000};

    // Only a 64-bit datapath has more than one 32-bit lane.
    generate
        if (XLEN == 64) begin : g_word64
            assign w_word_sh = rdata_i >> {offset_i[OFF_W-1], 5'b00000};
        end else begin : g_word32
            assign w_word_sh = rdata_i;
        end
    endgenerate

    always_comb begin
        ext_o = rdata_i;
        case (load_type_e'(load_type_i))
            LB:      ext_o = {{(XLEN-8){w_byte_sh[7]}},   w_byte_sh[7:0]};
            LBU:     ext_o = {{(XLEN-8){1'b0}},           w_byte_sh[7:0]};
            LH:      ext_o = {{(XLEN-16){w_half_sh[15]}}, w_half_sh[15:0]};
            LHU:     ext_o = {{(XLEN-16){1'b0}},          w_half_sh[15:0]};
            LW:      ext_o = XLEN'($signed(w_word_sh[31:0]));
            LWU:     ext_o = XLEN'(w_word_sh[31:0]);
            LD:      ext_o = rdata_i;
            default: ext_o = rdata_i;
        endcase
    end

endmodule : wb_load_extend
`default_nettype wire

// File: rtl/wb_mem_seg_mc.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mem_seg_mc
//  Description : MEM/WB write-back segment register driving a
//                variable-latency data memory over a req/ack handshake.
//                Aligns store lanes, extends load data, registers ALU/CSR
//                write-back values and stalls the pipe while a request is
//                outstanding.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                bubbleW, flushW        - hold / clear the WB segment
//                mem_read, mem_write    - MEM-stage op is load / store
//                wb_select              - 0: ALU result, 1: load data
//                load_type, store_be    - load kind, unshifted byte mask
//                addr, in_data          - byte address / ALU result, store data
//                CSR_result_MEM         - CSR value to forward
//                mem_req/we/addr/wdata  - memory request side
//                mem_ack, mem_rdata     - memory response side
//                stall_mem              - request outstanding
//                wb_valid               - one-cycle update strobe
//                data_WB, CSRWB         - write-back values
//                misalign_err           - (WB_MISALIGN_CHK_EN only) misaligned
//                                         access rejected this cycle
//  Options     : WB_MISALIGN_CHK_EN - reject non naturally aligned accesses
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_seg_mc
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AW    = 32,
    parameter int BE_W  = XLEN/8,
    parameter int OFF_W = $clog2(XLEN/8)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bubbleW,
    input  logic                flushW,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                wb_select,
    input  logic [2:0]          load_type,
    input  logic [BE_W-1:0]     store_be,
    input  logic [AW-1:0]       addr,
    input  logic [XLEN-1:0]     in_data,
    input  logic [XLEN-1:0]     CSR_result_MEM,
    output logic                mem_req,
    output logic [BE_W-1:0]     mem_we,
    output logic [AW-OFF_W-1:0] mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                stall_mem,
`ifdef WB_MISALIGN_CHK_EN
    output logic                misalign_err,
`endif
    output logic                wb_valid,
    output logic [XLEN-1:0]     data_WB,
    output logic [XLEN-1:0]     CSRWB
);

    wb_state_e          state_q;
    logic               req_q;
    logic [AW-1:0]      addr_q;
    logic [2:0]         load_type_q;
    logic               wb_select_q;
    logic               is_load_q;
    logic [XLEN-1:0]    csr_q;
    logic [BE_W-1:0]    we_q;
    logic [XLEN-1:0]    wdata_q;
    logic               flush_q;
    logic               wb_valid_q;
    logic [XLEN-1:0]    data_wb_q;
    logic [XLEN-1:0]    csrwb_q;

    logic [OFF_W-1:0]   w_off;
    logic [XLEN-1:0]    w_ext;
    logic               w_flush_hit;

    assign w_off = addr[OFF_W-1:0];

`ifdef WB_MISALIGN_CHK_EN
    logic               misalign_q;
    logic [3:0]         w_size;
    logic               w_aligned;

    // Loads size themselves from load_type, stores from the byte mask.
    assign w_size    = mem_read ? load_size_bytes(load_type)
                                : popcount8(8'(store_be));
    assign w_aligned = is_aligned(3'(w_off), w_size);
    assign misalign_err = misalign_q;
`endif

    // Extension uses the latched offset so it matches the issued request.
    wb_load_extend #(
        .XLEN        (XLEN),
        .OFF_W       (OFF_W)
    ) u_load_extend (
        .rdata_i     (mem_rdata),
        .offset_i    (addr_q[OFF_W-1:0]),
        .load_type_i (load_type_q),
        .ext_o       (w_ext)
    );

    // A flush seen at any point of the request, including the ack edge,
    // squashes the write-back but never the memory access itself.
    assign w_flush_hit = flush_q | flushW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            load_type_q <= '0;
            wb_select_q <= 1'b0;
            is_load_q   <= 1'b0;
            csr_q       <= '0;
            we_q        <= '0;
            wdata_q     <= '0;
            flush_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            data_wb_q   <= '0;
            csrwb_q     <= '0;
`ifdef WB_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            wb_valid_q <= 1'b0;
`ifdef WB_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bubbleW) begin
                        // hold everything
                    end else if (flushW) begin
                        data_wb_q  <= '0;
                        csrwb_q    <= '0;
                        wb_valid_q <= 1'b1;
                    end
`ifdef WB_MISALIGN_CHK_EN
                    else if ((mem_read || mem_write) && !w_aligned) begin
                        data_wb_q  <= '0;
                        csrwb_q    <= '0;
                        misalign_q <= 1'b1;
                        wb_valid_q <= 1'b1;
                    end
`endif
                    else if (mem_read || mem_write) begin
                        addr_q      <= addr;
                        load_type_q <= load_type;
                        wb_select_q <= wb_select;
                        is_load_q   <= mem_read;
                        csr_q       <= CSR_result_MEM;
                        we_q        <= mem_write ? (store_be << w_off) : '0;
                        wdata_q     <= in_data << {w_off, 3'b000};
                        flush_q     <= 1'b0;
                        req_q       <= 1'b1;
                        state_q     <= REQ;
                    end else begin
                        data_wb_q  <= wb_select ? '0 : XLEN'(addr);
                        csrwb_q    <= CSR_result_MEM;
                        wb_valid_q <= 1'b1;
                    end
                end

                REQ: begin
                    if (mem_ack) begin
                        if (w_flush_hit) begin
                            data_wb_q <= '0;
                            csrwb_q   <= '0;
                        end else begin
                            data_wb_q <= (is_load_q && wb_select_q) ? w_ext
                                                                    : XLEN'(addr_q);
                            csrwb_q   <= csr_q;
                        end
                        wb_valid_q <= 1'b1;
                        we_q       <= '0;
                        flush_q    <= 1'b0;
                        req_q      <= 1'b0;
                        state_q    <= IDLE;
                    end else if (flushW) begin
                        flush_q <= 1'b1;
                    end
                end

                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = req_q;
    assign stall_mem = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q[AW-1:OFF_W];
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign data_WB   = data_wb_q;
    assign CSRWB     = csrwb_q;

endmodule : wb_mem_seg_mc
`default_nettype wire
